// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder and ID/EX control register.
// Decodes instr_i into a control bundle, register indices and a sign-extended
// immediate, and detects load-use hazards against the instruction in EX.
// The output register gives flush priority over stall, and stall priority over
// the hazard bubble. It has a single cycle of latency.
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_W     = 5,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             ready_o,
  output logic             hazard_stall_o,
  output logic             valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [REG_W-1:0] rs1_o,
  output logic [REG_W-1:0] rs2_o,
  output logic [REG_W-1:0] rd_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             Branch_o,
  output logic             Jump_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             MemtoReg_o,
  output logic             illegal_o,
  output logic [1:0]       ALUOp_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_RFN  = 2'b10;
  localparam logic [1:0] ALU_IFN  = 2'b11;

  // One ID/EX register entry; an all-zero value is the bubble.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic             alu_src;
    logic             reg_write;
    logic             branch;
    logic             jump;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             illegal;
    logic [1:0]       alu_op;
  } id_ex_t;

  logic [6:0]       opcode;
  logic [REG_W-1:0] rs1_idx;
  logic [REG_W-1:0] rs2_idx;
  logic [REG_W-1:0] rd_idx;
  logic [31:0]      imm_i_fmt;
  logic [31:0]      imm_s_fmt;
  logic [31:0]      imm_b_fmt;
  logic [31:0]      imm_j_fmt;
  logic [31:0]      imm32;
  logic             rs1_used;
  logic             rs2_used;
  id_ex_t           dec;
  id_ex_t           idex_d;
  id_ex_t           idex_q;

  assign opcode  = instr_i[6:0];
  assign rs1_idx = REG_W'(instr_i[19:15]);
  assign rs2_idx = REG_W'(instr_i[24:20]);
  assign rd_idx  = REG_W'(instr_i[11:7]);

  // Raw 32-bit immediates for every format; B and J have an implicit bit 0 of 0.
  assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

  // JAL is the only format without an rs1; only R, store and branch read rs2.
  assign rs1_used = (opcode != OP_JAL);
  assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // A load in EX whose result is needed now must be waited on; x0 never counts.
  assign hazard_stall_o = HAZARD_EN && valid_i && ex_memread_i && (ex_rd_i != '0) &&
                          ((rs1_used && (ex_rd_i == rs1_idx)) ||
                           (rs2_used && (ex_rd_i == rs2_idx)));

  assign ready_o = flush_i | (~stall_i & ~hazard_stall_o);

  // Opcode-driven control bundle and immediate selection.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    dec       = '0;
    imm32     = '0;
    dec.valid = valid_i;
    dec.pc    = pc_i;
    dec.rs1   = rs1_idx;
    dec.rs2   = rs2_idx;
    dec.rd    = rd_idx;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_RFN;
      end
      OP_IMM: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_IFN;
        imm32         = imm_i_fmt;
      end
      OP_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_op     = ALU_ADD;
        imm32          = imm_i_fmt;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        imm32         = imm_s_fmt;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_BR;
        imm32      = imm_b_fmt;
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        imm32         = imm_j_fmt;
      end
      OP_JALR: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        imm32         = imm_i_fmt;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    if (rd_idx == '0) dec.reg_write = 1'b0;
    // A non-instruction carries its fields but must not act on anything downstream.
    if (!valid_i) begin
      dec.alu_src    = 1'b0;
      dec.reg_write  = 1'b0;
      dec.branch     = 1'b0;
      dec.jump       = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.illegal    = 1'b0;
      dec.alu_op     = 2'b00;
    end
  end

  // Next ID/EX value: flush, then stall (hold), then hazard bubble, then decode.
  always_comb begin
    idex_d = dec;
    if (flush_i) begin
      idex_d = '0;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (hazard_stall_o) begin
      idex_d = '0;
    end
  end

  // ID/EX register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_i) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign valid_o    = idex_q.valid;
  assign pc_o       = idex_q.pc;
  assign rs1_o      = idex_q.rs1;
  assign rs2_o      = idex_q.rs2;
  assign rd_o       = idex_q.rd;
  assign imm_o      = idex_q.imm;
  assign ALUSrc_o   = idex_q.alu_src;
  assign RegWrite_o = idex_q.reg_write;
  assign Branch_o   = idex_q.branch;
  assign Jump_o     = idex_q.jump;
  assign MemRead_o  = idex_q.mem_read;
  assign MemWrite_o = idex_q.mem_write;
  assign MemtoReg_o = idex_q.mem_to_reg;
  assign illegal_o  = idex_q.illegal;
  assign ALUOp_o    = idex_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage.
// The driver pushes the hand-computed ID/EX contents expected after each edge;
// a monitor pops and compares on every falling edge.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ex_memread_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;

  logic        ready_o, hazard_stall_o, valid_o;
  logic [31:0] pc_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        ALUSrc_o, RegWrite_o, Branch_o, Jump_o;
  logic        MemRead_o, MemWrite_o, MemtoReg_o, illegal_o;
  logic [1:0]  ALUOp_o;

  decode_stage #(.XLEN(32), .REG_W(5), .HAZARD_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .ready_o(ready_o), .hazard_stall_o(hazard_stall_o), .valid_o(valid_o),
    .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
    .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o), .Branch_o(Branch_o),
    .Jump_o(Jump_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .MemtoReg_o(MemtoReg_o), .illegal_o(illegal_o), .ALUOp_o(ALUOp_o)
  );

  always #5 clk_i = ~clk_i;

  // ctl order: {ALUSrc, RegWrite, Branch, Jump, MemRead, MemWrite, MemtoReg, illegal}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  ctl;
    logic [1:0]  alu_op;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  last_exp = '0;
  int    n_checks = 0;
  int    n_fail   = 0;

  localparam exp_t BUBBLE = '0;

  function automatic exp_t mk(input logic v, input logic [31:0] pc,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm,
                              input logic [7:0] ctl, input logic [1:0] alu_op);
    exp_t e;
    e.valid = v; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.imm = imm; e.ctl = ctl; e.alu_op = alu_op;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.valid  = valid_o; a.pc = pc_o; a.rs1 = rs1_o; a.rs2 = rs2_o; a.rd = rd_o;
    a.imm    = imm_o;
    a.ctl    = {ALUSrc_o, RegWrite_o, Branch_o, Jump_o,
                MemRead_o, MemWrite_o, MemtoReg_o, illegal_o};
    a.alu_op = ALUOp_o;
    return a;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, check the combinational
  // outputs, and queue the register contents expected after the next rising edge.
  task automatic step(input string name, input logic [31:0] instr, input logic [31:0] pc,
                      input logic v, input logic st, input logic fl,
                      input logic mr, input logic [4:0] erd,
                      input exp_t exp, input logic exp_haz, input logic exp_rdy);
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    instr_i = instr; pc_i = pc; valid_i = v; stall_i = st; flush_i = fl;
    ex_memread_i = mr; ex_rd_i = erd;
    #1;
    check({name, "_hazard"}, 128'(hazard_stall_o), 128'(exp_haz));
    check({name, "_ready"},  128'(ready_o),        128'(exp_rdy));
    exp_q.push_back(exp);
    name_q.push_back(name);
    last_exp = exp;
  endtask

  // Monitor: compare the registered bundle once per cycle, away from the rising edge.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, 128'(actual()), 128'(e));
      end
    end
  end

  // Stimulus.
  initial begin
    exp_t e_add, e_addi, e_add6;
    e_add  = mk(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd0, 8'b0100_0000, 2'b10);
    e_addi = mk(1'b1, 32'h104, 5'd0, 5'd5, 5'd1, 32'd5, 8'b1100_0000, 2'b11);
    e_add6 = mk(1'b1, 32'h120, 5'd5, 5'd1, 5'd6, 32'd0, 8'b0100_0000, 2'b10);

    #3;
    check("reset_state", 128'(actual()), 128'(BUBBLE));

    step("add",  32'h002081B3, 32'h100, 1, 0, 0, 0, 5'd0, e_add, 0, 1);

    // Asynchronous reset between edges while valid_o=1.
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1 check("async_reset", 128'(actual()), 128'(BUBBLE));
    exp_q.push_back(BUBBLE);
    name_q.push_back("reset_held");
    step("add_after_reset", 32'h002081B3, 32'h100, 1, 0, 0, 0, 5'd0, e_add, 0, 1);

    step("addi", 32'h00500093, 32'h104, 1, 0, 0, 0, 5'd0, e_addi, 0, 1);
    step("beq",  32'h00208463, 32'h108, 1, 0, 0, 0, 5'd0,
         mk(1'b1, 32'h108, 5'd1, 5'd2, 5'd8, 32'd8, 8'b0010_0000, 2'b01), 0, 1);
    step("sw_neg", 32'hFE20AE23, 32'h10C, 1, 0, 0, 0, 5'd0,
         mk(1'b1, 32'h10C, 5'd1, 5'd2, 5'd28, 32'hFFFF_FFFC, 8'b1000_0100, 2'b00), 0, 1);
    step("jal",  32'h010000EF, 32'h110, 1, 0, 0, 0, 5'd0,
         mk(1'b1, 32'h110, 5'd0, 5'd16, 5'd1, 32'd16, 8'b0101_0000, 2'b00), 0, 1);
    step("jalr", 32'h004100E7, 32'h114, 1, 0, 0, 0, 5'd0,
         mk(1'b1, 32'h114, 5'd2, 5'd4, 5'd1, 32'd4, 8'b1101_0000, 2'b00), 0, 1);
    step("lw",   32'h00012283, 32'h118, 1, 0, 0, 0, 5'd0,
         mk(1'b1, 32'h118, 5'd2, 5'd0, 5'd5, 32'd0, 8'b1100_1010, 2'b00), 0, 1);

    // Load-use on rs1, then release.
    step("loaduse_bubble", 32'h00128333, 32'h120, 1, 0, 0, 1, 5'd5, BUBBLE, 1, 0);
    step("loaduse_release", 32'h00128333, 32'h120, 1, 0, 0, 0, 5'd5, e_add6, 0, 1);

    // No hazard when the load targets x0, nor on an unused rs2 field.
    step("exrd_zero", 32'h00500093, 32'h104, 1, 0, 0, 1, 5'd0, e_addi, 0, 1);
    step("rs2_unused", 32'h00500093, 32'h104, 1, 0, 0, 1, 5'd5, e_addi, 0, 1);

    // Flush beats stall.
    step("flush_stall", 32'h002081B3, 32'h100, 1, 1, 1, 0, 5'd0, BUBBLE, 0, 1);
    step("add_reload", 32'h002081B3, 32'h100, 1, 0, 0, 0, 5'd0, e_add, 0, 1);

    // Stall holds for three cycles while the inputs change.
    step("stall1", 32'h00500093, 32'h104, 1, 1, 0, 0, 5'd0, last_exp, 0, 0);
    step("stall2", 32'h0000007F, 32'h108, 1, 1, 0, 0, 5'd0, last_exp, 0, 0);
    step("stall3", 32'h00208463, 32'h10C, 0, 1, 0, 0, 5'd0, last_exp, 0, 0);

    // Stall together with a hazard: hold, hazard still reported.
    step("stall_hazard", 32'h00128333, 32'h120, 1, 1, 0, 1, 5'd5, last_exp, 1, 0);

    step("illegal", 32'h0000007F, 32'h130, 1, 0, 0, 0, 5'd0,
         mk(1'b1, 32'h130, 5'd0, 5'd0, 5'd0, 32'd0, 8'b0000_0001, 2'b00), 0, 1);
    step("addi_x0", 32'h00100013, 32'h134, 1, 0, 0, 0, 5'd0,
         mk(1'b1, 32'h134, 5'd0, 5'd1, 5'd0, 32'd1, 8'b1000_0000, 2'b11), 0, 1);
    step("invalid_in", 32'h002081B3, 32'h138, 0, 0, 0, 0, 5'd0,
         mk(1'b0, 32'h138, 5'd1, 5'd2, 5'd3, 32'd0, 8'b0000_0000, 2'b00), 0, 1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
